// File: rtl/serial_tx_pkg.sv
// Shared constants, FSM state type and width helper for the serial transmit scheduler.
package serial_tx_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Bits needed to index 'value' entries, never below one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping modulo NUM_REQ.
module rr_arbiter
  import serial_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one 8-bit PISO shift register between requesters,
// with per-bit qualifiers aligned to the shift register's serial output.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned GAP_CYCLES = 0,
  localparam int unsigned SRC_W      = clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   sr_load,
  output logic [FRAME_BITS-1:0]  sr_data_in,
  output logic                   bit_valid,
  output logic                   bit_first,
  output logic                   bit_last,
  output logic [SRC_W-1:0]       bit_src,
  output logic                   busy
);

  localparam int unsigned     PERIOD   = FRAME_BITS + GAP_CYCLES;
  localparam int unsigned     CNT_W    = clog2(PERIOD);
  localparam int unsigned     WIN_W    = clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FRAME_BITS - 1);
  localparam logic [WIN_W-1:0] WIN_PRE  = WIN_W'(FRAME_BITS - 2);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   pend_src;
  logic [SRC_W-1:0]   win_idx;
  logic [SRC_W-1:0]   arm_src;
  logic [WIN_W-1:0]   win_cnt;
  logic [NUM_REQ-1:0] grant;
  logic               window_c;
  logic               hs_c;
  logic               arm;

  // Grants only while idle or in the last cycle of the load period; silent during reset.
  assign window_c = !rst && ((state == IDLE) || ((state == RUN) && (cnt == CNT_LAST)));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (window_c),
    .grant  (grant),
    .idx    (win_idx)
  );

  assign req_ready = grant;
  assign hs_c      = |(req_valid & grant);

  // Load-spacing FSM; a handshake always leads to a one-cycle LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= SRC_W'(NUM_REQ - 1);
      pend_src   <= '0;
      sr_load    <= 1'b0;
      sr_data_in <= '0;
    end else begin
      sr_load <= 1'b0;
      if (hs_c) begin
        sr_data_in <= req_data[32'(win_idx)*8 +: 8];
        pend_src   <= win_idx;
        ptr        <= win_idx;
        sr_load    <= 1'b1;
        state      <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            state <= RUN;
            cnt   <= CNT_W'(1);
          end
          RUN: begin
            if (cnt == CNT_LAST) state <= IDLE;
            else                 cnt   <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bit-window tracker: arm stage holds the next frame's source while the current one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm       <= 1'b0;
      arm_src   <= '0;
      win_cnt   <= '0;
      bit_valid <= 1'b0;
      bit_first <= 1'b0;
      bit_last  <= 1'b0;
      bit_src   <= '0;
      busy      <= 1'b0;
    end else begin
      arm       <= sr_load;
      arm_src   <= pend_src;
      bit_first <= arm;
      busy      <= hs_c || sr_load || arm || (bit_valid && (win_cnt != WIN_LAST));
      if (arm) begin
        bit_valid <= 1'b1;
        bit_last  <= 1'b0;
        win_cnt   <= '0;
        bit_src   <= arm_src;
      end else if (bit_valid) begin
        if (win_cnt == WIN_LAST) begin
          bit_valid <= 1'b0;
          bit_last  <= 1'b0;
        end else begin
          win_cnt  <= win_cnt + WIN_W'(1);
          bit_last <= (win_cnt == WIN_PRE);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: a gap-0 and a gap-3 instance checked every cycle
// against a frame-level reference model plus a model of the downstream shift register.
module tb_serial_tx_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned SRC_W   = 1;
  localparam int unsigned GAP0    = 0;
  localparam int unsigned GAP1    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NUM_REQ-1:0]   vld   [2];
  logic [8*NUM_REQ-1:0] dat   [2];
  logic [NUM_REQ-1:0]   rdy   [2];
  logic                 sload [2];
  logic [7:0]           sdin  [2];
  logic                 bv    [2];
  logic                 bf    [2];
  logic                 bl    [2];
  logic [SRC_W-1:0]     bs    [2];
  logic                 bsy   [2];

  serial_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP0)) u_gap0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_data(dat[0]), .req_ready(rdy[0]),
    .sr_load(sload[0]), .sr_data_in(sdin[0]), .bit_valid(bv[0]), .bit_first(bf[0]),
    .bit_last(bl[0]), .bit_src(bs[0]), .busy(bsy[0]));

  serial_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP1)) u_gap3 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_data(dat[1]), .req_ready(rdy[1]),
    .sr_load(sload[1]), .sr_data_in(sdin[1]), .bit_valid(bv[1]), .bit_first(bf[1]),
    .bit_last(bl[1]), .bit_src(bs[1]), .busy(bsy[1]));

  always #5 clk = ~clk;

  // Downstream shift register: shifts every clock, output bit registered.
  logic [7:0] srm  [2];
  logic       dout [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      dout[k] <= srm[k][0];
      srm[k]  <= sload[k] ? sdin[k] : {1'b0, srm[k][7:1]};
    end
  end

  int         checks;
  int         errors;
  longint     cyc;
  longint     last_h   [2];
  int         ptr      [2];
  longint     fl       [2][2];
  logic [7:0] fb       [2][2];
  int         fs       [2][2];
  logic [7:0] sdi      [2];
  logic       granted  [2][NUM_REQ];
  longint     obs_hs   [2][NUM_REQ];
  int         gord     [2][8];
  int         ng       [2];
  longint     last_load[2];
  longint     sp_min   [2];
  longint     sp_max   [2];
  logic [7:0] cap      [2];
  int         ncap     [2];
  int         waitn;

  function automatic longint period(input int k);
    return (k == 0) ? longint'(8 + GAP0) : longint'(8 + GAP1);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_h[k] = -1000;
      ptr[k]    = NUM_REQ - 1;
      fl[k][0]  = -1000;
      fl[k][1]  = -1000;
      sdi[k]    = 8'h00;
      for (int j = 0; j < NUM_REQ; j++) granted[k][j] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", k, 32'(rdy[k]), 32'd0);
      chk("rst_sr_load", k, 32'(sload[k]), 32'd0);
      chk("rst_sr_data_in", k, 32'(sdin[k]), 32'd0);
      chk("rst_bit_valid", k, 32'(bv[k]), 32'd0);
      chk("rst_bit_first", k, 32'(bf[k]), 32'd0);
      chk("rst_bit_last", k, 32'(bl[k]), 32'd0);
      chk("rst_bit_src", k, 32'(bs[k]), 32'd0);
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
    end
  endtask

  // Frame-level expectations for one cycle: grant window opens P cycles after the last handshake.
  task automatic check_cycle(input int k);
    logic [NUM_REQ-1:0] exp_rdy;
    int   win;
    int   esrc;
    logic ev, ef, el, eb, ebit;
    exp_rdy = '0;
    win     = -1;
    if (cyc - last_h[k] >= period(k)) begin
      for (int j = 1; j <= NUM_REQ; j++) begin
        int c;
        c = (ptr[k] + j) % NUM_REQ;
        if (win < 0 && vld[k][c]) win = c;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", k, 32'(rdy[k]), 32'(exp_rdy));
    chk("sr_load", k, 32'(sload[k]), 32'(fl[k][0] == cyc));
    chk("sr_data_in", k, 32'(sdin[k]), 32'(sdi[k]));
    ev = 0; ef = 0; el = 0; eb = 0; ebit = 0; esrc = 0;
    for (int f = 0; f < 2; f++) begin
      if (cyc >= fl[k][f] && cyc <= fl[k][f] + 9) eb = 1;
      if (cyc >= fl[k][f] + 2 && cyc <= fl[k][f] + 9) begin
        ev   = 1;
        ef   = (cyc == fl[k][f] + 2);
        el   = (cyc == fl[k][f] + 9);
        esrc = fs[k][f];
        ebit = fb[k][f][int'(cyc - fl[k][f] - 2)];
      end
    end
    chk("bit_valid", k, 32'(bv[k]), 32'(ev));
    chk("bit_first", k, 32'(bf[k]), 32'(ef));
    chk("bit_last", k, 32'(bl[k]), 32'(el));
    chk("busy", k, 32'(bsy[k]), 32'(eb));
    if (ev) begin
      chk("bit_src", k, 32'(bs[k]), 32'(esrc));
      chk("data_out", k, 32'(dout[k]), 32'(ebit));
    end
    // Observations used by the directed checks.
    if (bv[k] === 1'b1) begin
      cap[k] = {dout[k], cap[k][7:1]};
      ncap[k]++;
    end
    if (sload[k] === 1'b1) begin
      if (last_load[k] >= 0) begin
        if (cyc - last_load[k] < sp_min[k]) sp_min[k] = cyc - last_load[k];
        if (cyc - last_load[k] > sp_max[k]) sp_max[k] = cyc - last_load[k];
      end
      last_load[k] = cyc;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rdy[k][j] === 1'b1 && vld[k][j]) begin
        obs_hs[k][j] = cyc;
        if (ng[k] < 8) gord[k][ng[k]] = j;
        ng[k]++;
      end
    end
    if (win >= 0) begin
      last_h[k]  = cyc;
      ptr[k]     = win;
      fl[k][1]   = fl[k][0];
      fb[k][1]   = fb[k][0];
      fs[k][1]   = fs[k][0];
      fl[k][0]   = cyc + 1;
      fb[k][0]   = dat[k][8*win +: 8];
      fs[k][0]   = win;
      sdi[k]     = dat[k][8*win +: 8];
      granted[k][win] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_cycle(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    model_reset();
  endtask

  // sticky: keep requests up after a grant; rnd: free requesters randomly raise new bytes.
  task automatic run(input int n, input bit sticky, input bit rnd);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < NUM_REQ; j++) granted[k][j] = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (granted[k][j] && !sticky) vld[k][j] = 1'b0;
          if (rnd && !vld[k][j] && $urandom_range(0, 2) == 0) begin
            vld[k][j]         = 1'b1;
            dat[k][8*j +: 8] = 8'($urandom);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = '0;
      dat[k] = '0;
      last_load[k] = -1;
      sp_min[k] = 1000000;
      sp_max[k] = 0;
      ng[k] = 0;
      ncap[k] = 0;
      cap[k] = 8'h00;
    end
    model_reset();

    // Reset held three cycles, then idle.
    do_reset(3);
    run(20, 1'b0, 1'b0);

    // Single byte A5 from requester 0.
    do_reset(2);
    for (int k = 0; k < 2; k++) begin ncap[k] = 0; cap[k] = 8'h00; end
    run(4, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin vld[k] = 2'b01; dat[k] = 16'h00A5; end
    run(16, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("single_stream", k, 32'(cap[k]), 32'h0000_00A5);
      chk("single_nbits", k, 32'(ncap[k]), 32'd8);
    end

    // Contention: both requesters always valid.
    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      ng[k] = 0; last_load[k] = -1; sp_min[k] = 1000000; sp_max[k] = 0;
      vld[k] = 2'b11; dat[k] = 16'h2211;
    end
    run(48, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rr_order0", k, 32'(gord[k][0]), 32'd0);
      chk("rr_order1", k, 32'(gord[k][1]), 32'd1);
      chk("rr_order2", k, 32'(gord[k][2]), 32'd0);
      chk("rr_order3", k, 32'(gord[k][3]), 32'd1);
      chk("load_spacing_min", k, 32'(sp_min[k]), 32'(period(k)));
      chk("load_spacing_max", k, 32'(sp_max[k]), 32'(period(k)));
    end
    for (int k = 0; k < 2; k++) vld[k] = '0;
    run(20, 1'b0, 1'b0);

    // Late request: req1 rises three cycles into req0's load period; a short req0 blip is ignored.
    for (int k = 0; k < 2; k++) begin
      obs_hs[k][0] = -1; obs_hs[k][1] = -1;
      vld[k] = 2'b01; dat[k] = 16'hC33C;
    end
    run(4, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) vld[k][1] = 1'b1;
    run(1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) vld[k][0] = 1'b1;
    run(1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) vld[k][0] = 1'b0;
    run(16, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++)
      chk("late_grant_delay", k, 32'(obs_hs[k][1] - obs_hs[k][0]), 32'(period(k)));

    // Randomized traffic, then drain.
    run(600, 1'b0, 1'b1);
    run(30, 1'b0, 1'b0);

    // Reset during bit 4 of a frame with both requesters pending.
    for (int k = 0; k < 2; k++) begin vld[k] = 2'b11; dat[k] = 16'h5A96; end
    waitn = 0;
    while (bf[0] !== 1'b1 && waitn < 30) begin
      run(1, 1'b1, 1'b0);
      waitn++;
    end
    chk("first_bit_seen", 0, 32'(bf[0]), 32'd1);
    run(4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) chk("post_rst_grant", k, 32'(rdy[k]), 32'd1);
    run(30, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
